// File: rtl/capture_dump_pkg.sv
// Shared state encoding and sizing helpers for the capture RAM readout engine.
package capture_dump_pkg;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_FETCH = 5'b00010,
        S_SEND  = 5'b00100,
        S_CSUM  = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    function automatic int bytes_per_sample(input int sample_w);
        return sample_w / 8;
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat == 1) || (rd_lat == 2);
    endfunction

endpackage

// File: rtl/capture_dump_ser.sv
// Sample shift register: loads one RAM word and hands it out MSB-first, one byte per shift.
module capture_dump_ser
    import capture_dump_pkg::*;
#(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                shift,
    input  logic [SAMPLE_W-1:0] din,
    output logic [7:0]          cur_byte,
    output logic                last_byte
);

    localparam int BPS   = bytes_per_sample(SAMPLE_W);
    localparam int IDX_W = (BPS > 1) ? $clog2(BPS) : 1;

    logic [SAMPLE_W-1:0] sreg;
    logic [IDX_W-1:0]    idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= din;
            idx  <= IDX_W'(BPS - 1);
        end else if (shift) begin
            sreg <= sreg << 8;
            idx  <= idx - IDX_W'(1);
        end
    end

    assign cur_byte  = sreg[SAMPLE_W-1 -: 8];
    assign last_byte = (idx == '0);

endmodule

// File: rtl/capture_dump.sv
// Capture RAM readout engine: streams a circular window of samples as bytes.
// Optional trailing checksum byte when CAPTURE_DUMP_CSUM_EN is defined.
module capture_dump
    import capture_dump_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 8,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                grant_txd,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     length,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [SAMPLE_W-1:0] rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_data_valid,
    input  logic                tx_data_ack,
    output logic                busy,
    output logic                done_txd
);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("capture_dump: RD_LAT must be 1 or 2");
    end

    state_t            state_q, state_d;
    logic [ADDR_W:0]   remaining;
    logic [1:0]        fetch_cnt;
    logic              armed;
    logic              start, ack, load, shift, more_samples;
    logic [7:0]        cur_byte;
    logic              last_byte;

    assign start        = (state_q == S_IDLE) && grant_txd && armed;
    assign ack          = tx_data_valid && tx_data_ack;
    assign load         = (state_q == S_FETCH) && (fetch_cnt == 2'(RD_LAT));
    assign shift        = (state_q == S_SEND) && ack && !last_byte;
    assign more_samples = remaining > (ADDR_W+1)'(1);

    capture_dump_ser #(.SAMPLE_W(SAMPLE_W)) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .din       (rd_data),
        .cur_byte  (cur_byte),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (load)  state_d = S_SEND;
            S_SEND: begin
                if (ack && last_byte) begin
                    if (more_samples) state_d = S_FETCH;
`ifdef CAPTURE_DUMP_CSUM_EN
                    else              state_d = S_CSUM;
`else
                    else              state_d = S_DONE;
`endif
                end
            end
`ifdef CAPTURE_DUMP_CSUM_EN
            S_CSUM:  if (ack) state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CAPTURE_DUMP_CSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          sum <= '0;
        else if (start)                      sum <= '0;
        else if (state_q == S_SEND && ack)   sum <= sum + cur_byte;
    end

    // Two's complement so the receiver's running sum over all bytes lands on zero.
    always_comb begin
        tx_data_valid = (state_q == S_SEND) || (state_q == S_CSUM);
        tx_data       = (state_q == S_CSUM) ? (~sum + 8'd1) : cur_byte;
        busy          = (state_q != S_IDLE);
        done_txd      = (state_q == S_DONE);
    end
`else
    always_comb begin
        tx_data_valid = (state_q == S_SEND);
        tx_data       = cur_byte;
        busy          = (state_q != S_IDLE);
        done_txd      = (state_q == S_DONE);
    end
`endif

    // Armed only re-sets after grant is seen low, so a held grant yields one dump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            remaining <= '0;
            fetch_cnt <= '0;
            armed     <= 1'b1;
        end else begin
            if (!grant_txd)  armed <= 1'b1;
            else if (start)  armed <= 1'b0;

            fetch_cnt <= (state_q == S_FETCH) ? fetch_cnt + 2'd1 : 2'd0;

            if (start) begin
                rd_addr   <= start_addr;
                remaining <= (length == '0) ? {1'b1, {ADDR_W{1'b0}}} : length;
            end else if (state_q == S_SEND && ack && last_byte && more_samples) begin
                rd_addr   <= rd_addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
        end
    end

endmodule
